// File: rtl/lenet5_frame_ctrl.sv
// Frame-level scheduler for the LeNet-5 core: accepts a frame, flushes and runs the core,
// returns the class (or a watchdog abort code) through a valid/ready result port.
module lenet5_frame_ctrl #(
  parameter int unsigned I_SIZE  = 28,
  parameter int unsigned I_BW    = 8,
  parameter int unsigned RST_CYC = 4,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic                         clk,
  input  logic                         global_rst_n,
  input  logic                         i_frame_valid,
  input  logic [I_SIZE*I_SIZE*I_BW-1:0] i_frame,
  output logic                         o_frame_ready,
  output logic [I_SIZE*I_SIZE*I_BW-1:0] o_core_fmap,
  output logic                         o_core_rst,
  output logic                         o_core_ce,
  input  logic                         i_core_end,
  input  logic [3:0]                   i_core_result,
  output logic                         o_res_valid,
  output logic [3:0]                   o_res_data,
  output logic                         o_res_err,
  input  logic                         i_res_ready,
  output logic                         o_busy,
  output logic [15:0]                  o_frame_cnt
);

  localparam int unsigned FW = I_SIZE * I_SIZE * I_BW;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_RUN,
    S_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [FW-1:0]   r_fmap;
  logic [3:0]      r_res_data;
  logic            r_res_err;
  logic [15:0]     r_frame_cnt;

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) r_state <= S_IDLE;
    else               r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_frame_valid)                  w_next = S_FLUSH;
      S_FLUSH: if (r_cnt == RST_LAST)              w_next = S_RUN;
      S_RUN:   if (i_core_end || r_cnt == TO_LAST) w_next = S_HOLD;
      S_HOLD:  if (i_res_ready)                    w_next = S_IDLE;
      default:                                     w_next = S_IDLE;
    endcase
  end

  // One phase counter serves both the flush length and the run watchdog.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      r_cnt       <= '0;
      r_fmap      <= '0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_frame_valid) begin
            r_fmap <= i_frame;
            r_cnt  <= '0;
          end
        end
        S_FLUSH: begin
          if (r_cnt == RST_LAST) r_cnt <= '0;
          else                   r_cnt <= r_cnt + 1'b1;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_core_end) begin
            r_res_data <= i_core_result;
            r_res_err  <= 1'b0;
          end else if (r_cnt == TO_LAST) begin
            r_res_data <= 4'hF;
            r_res_err  <= 1'b1;
          end
        end
        S_HOLD: begin
          if (i_res_ready) r_frame_cnt <= r_frame_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_frame_ready = (r_state == S_IDLE);
  assign o_core_rst    = (r_state == S_FLUSH);
  assign o_core_ce     = (r_state == S_RUN);
  assign o_res_valid   = (r_state == S_HOLD);
  assign o_busy        = (r_state != S_IDLE);
  assign o_core_fmap   = r_fmap;
  assign o_res_data    = r_res_data;
  assign o_res_err     = r_res_err;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_lenet5_frame_ctrl.sv
// Directed bench for lenet5_frame_ctrl: one instance with the default watchdog,
// one with TIMEOUT=16 for abort and end/timeout coincidence cases.
module tb_lenet5_frame_ctrl;

  localparam int unsigned FW = 28 * 28 * 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          fv    [2];
  logic [FW-1:0] frame [2];
  logic          fr    [2];
  logic [FW-1:0] fmap  [2];
  logic          crst  [2];
  logic          cce   [2];
  logic          cend  [2];
  logic [3:0]    cres  [2];
  logic          rv    [2];
  logic [3:0]    rd    [2];
  logic          re    [2];
  logic          rr    [2];
  logic          busy  [2];
  logic [15:0]   fcnt  [2];

  lenet5_frame_ctrl #(.I_SIZE(28), .I_BW(8), .RST_CYC(4), .TIMEOUT(4095)) u_dut0 (
    .clk(clk), .global_rst_n(rst_n),
    .i_frame_valid(fv[0]), .i_frame(frame[0]), .o_frame_ready(fr[0]),
    .o_core_fmap(fmap[0]), .o_core_rst(crst[0]), .o_core_ce(cce[0]),
    .i_core_end(cend[0]), .i_core_result(cres[0]),
    .o_res_valid(rv[0]), .o_res_data(rd[0]), .o_res_err(re[0]), .i_res_ready(rr[0]),
    .o_busy(busy[0]), .o_frame_cnt(fcnt[0])
  );

  lenet5_frame_ctrl #(.I_SIZE(28), .I_BW(8), .RST_CYC(4), .TIMEOUT(16)) u_dut1 (
    .clk(clk), .global_rst_n(rst_n),
    .i_frame_valid(fv[1]), .i_frame(frame[1]), .o_frame_ready(fr[1]),
    .o_core_fmap(fmap[1]), .o_core_rst(crst[1]), .o_core_ce(cce[1]),
    .i_core_end(cend[1]), .i_core_result(cres[1]),
    .o_res_valid(rv[1]), .o_res_data(rd[1]), .o_res_err(re[1]), .i_res_ready(rr[1]),
    .o_busy(busy[1]), .o_frame_cnt(fcnt[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Accept a frame, count flush and run cycles; the core model pulses end on
  // run cycle end_at (0 = never). Returns at the first negedge after RUN ends.
  task automatic run_frame(input int s, input logic [FW-1:0] f, input int end_at,
                           input logic [3:0] res, output int n_rst, output int n_ce);
    fv[s] = 1'b1; frame[s] = f;
    tick;
    fv[s] = 1'b0;
    n_rst = 0;
    while (crst[s] && n_rst < 64) begin n_rst++; tick; end
    n_ce = 0;
    while (cce[s] && n_ce < 8192) begin
      n_ce++;
      if (n_ce == end_at) begin cend[s] = 1'b1; cres[s] = res; end
      tick;
      cend[s] = 1'b0; cres[s] = 4'h0;
    end
  endtask

  task automatic handoff(input int s);
    rr[s] = 1'b1;
    tick;
    rr[s] = 1'b0;
  endtask

  logic [FW-1:0] F1, F2, F3, F4, F5, F6;
  int nr, nc;
  logic bp_ok;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    F1 = {(FW/32){32'h0102_0304}};
    F2 = {(FW/32){32'hA5A5_5A5A}};
    F3 = {(FW/32){32'hDEAD_BEEF}};
    F4 = {(FW/32){32'h1357_9BDF}};
    F5 = {(FW/32){32'h0F0F_F0F0}};
    F6 = {(FW/32){32'h7777_1111}};
    for (int i = 0; i < 2; i++) begin
      fv[i] = 1'b0; frame[i] = '0; cend[i] = 1'b0; cres[i] = 4'h0; rr[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) tick;

    chk("rst_busy", busy[0], 0);
    chk("rst_ce", cce[0], 0);
    chk("rst_crst", crst[0], 0);
    chk("rst_rv", rv[0], 0);
    chk("rst_rd", rd[0], 0);
    chk("rst_fcnt", fcnt[0], 0);
    chk("rst_fmap_zero", fmap[0] == '0, 1);
    rst_n = 1'b1;
    tick;
    chk("idle_ready", fr[0], 1);

    // Normal frame: 4 flush cycles, end with class 7 after 100 run cycles.
    run_frame(0, F1, 100, 4'd7, nr, nc);
    chk("norm_rst_cycles", nr, 4);
    chk("norm_ce_cycles", nc, 100);
    chk("norm_rv", rv[0], 1);
    chk("norm_rd", rd[0], 7);
    chk("norm_err", re[0], 0);
    chk("norm_fmap", fmap[0] == F1, 1);

    // Back-pressure with a new frame waiting.
    fv[0] = 1'b1; frame[0] = F2;
    bp_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!(rv[0] && rd[0] == 4'd7 && !re[0] && fmap[0] == F1 && !fr[0] && !cce[0]))
        bp_ok = 1'b0;
      tick;
    end
    chk("bp_stable", bp_ok, 1);
    handoff(0);
    chk("bp_ready_after_hs", fr[0], 1);
    chk("bp_rv_after_hs", rv[0], 0);
    chk("norm_fcnt", fcnt[0], 1);
    chk("bp_fmap_not_yet", fmap[0] == F1, 1);
    tick;
    fv[0] = 1'b0;
    chk("bp_accept_busy", busy[0], 1);
    chk("bp_accept_flush", crst[0], 1);
    chk("bp_accept_fmap", fmap[0] == F2, 1);

    // Reset mid-RUN at run cycle 30, between clock edges.
    repeat (4) tick;
    repeat (29) tick;
    chk("mid_run_ce", cce[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ce", cce[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_rv", rv[0], 0);
    chk("arst_rd", rd[0], 0);
    chk("arst_err", re[0], 0);
    chk("arst_fcnt", fcnt[0], 0);
    chk("arst_fmap_zero", fmap[0] == '0, 1);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_ready", fr[0], 1);
    chk("post_rst_fcnt", fcnt[0], 0);
    run_frame(0, F3, 10, 4'd9, nr, nc);
    chk("post_rst_rcyc", nr, 4);
    chk("post_rst_ccyc", nc, 10);
    chk("post_rst_rd", rd[0], 9);
    handoff(0);
    chk("post_rst_fcnt1", fcnt[0], 1);

    // Watchdog: core never ends, abort after 16 run cycles.
    run_frame(1, F4, 0, 4'h0, nr, nc);
    chk("wd_rst_cycles", nr, 4);
    chk("wd_ce_cycles", nc, 16);
    chk("wd_latency", nr + nc, 20);
    chk("wd_rv", rv[1], 1);
    chk("wd_rd", rd[1], 4'hF);
    chk("wd_err", re[1], 1);
    cend[1] = 1'b1; cres[1] = 4'd5;
    repeat (3) tick;
    chk("wd_late_end_rd", rd[1], 4'hF);
    chk("wd_late_end_err", re[1], 1);
    handoff(1);
    repeat (3) tick;
    chk("wd_late_end_idle_rv", rv[1], 0);
    chk("wd_late_end_idle_busy", busy[1], 0);
    cend[1] = 1'b0; cres[1] = 4'h0;
    chk("wd_fcnt", fcnt[1], 1);

    // End and timeout in the same cycle: end wins.
    run_frame(1, F5, 16, 4'd3, nr, nc);
    chk("coin_ce_cycles", nc, 16);
    chk("coin_rd", rd[1], 3);
    chk("coin_err", re[1], 0);
    handoff(1);
    chk("coin_fcnt", fcnt[1], 2);

    // Frame counter wrap, then a spurious end pulse in IDLE.
    force u_dut0.r_frame_cnt = 16'hFFFF;
    #1;
    release u_dut0.r_frame_cnt;
    #1;
    chk("wrap_preload", fcnt[0], 16'hFFFF);
    run_frame(0, F6, 1, 4'd2, nr, nc);
    chk("wrap_ccyc", nc, 1);
    chk("wrap_rd", rd[0], 2);
    handoff(0);
    chk("wrap_fcnt", fcnt[0], 0);
    cend[0] = 1'b1; cres[0] = 4'd8;
    repeat (2) tick;
    cend[0] = 1'b0; cres[0] = 4'h0;
    tick;
    chk("spur_rv", rv[0], 0);
    chk("spur_busy", busy[0], 0);
    chk("spur_rd", rd[0], 2);
    chk("spur_ready", fr[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
